// File: rtl/median_first_actor_if.sv
// Handshake bundle of the median head actor: the raw pixel input FIFO and
// the five output FIFOs that feed the first middle actor.
interface median_first_actor_if #(
    parameter int BUFF_SIZE_BIT = 11
);
    logic [7:0]               in_px;
    logic                     in_px_rd;
    logic                     in_px_empty;
    logic [7:0]               out_px;
    logic                     out_px_wr;
    logic                     out_px_full;
    logic [7:0]               out_pivot;
    logic                     out_pivot_wr;
    logic                     out_pivot_full;
    logic [BUFF_SIZE_BIT-1:0] out_buff_size;
    logic                     out_buff_size_wr;
    logic                     out_buff_size_full;
    logic [BUFF_SIZE_BIT-1:0] out_median_pos;
    logic                     out_median_pos_wr;
    logic                     out_median_pos_full;
    logic [7:0]               out_second_median_value;
    logic                     out_second_median_value_wr;
    logic                     out_second_median_value_full;

    // Actor side: pops the input FIFO, pushes the output FIFOs.
    modport master (
        input  in_px, in_px_empty,
        input  out_px_full, out_pivot_full, out_buff_size_full,
        input  out_median_pos_full, out_second_median_value_full,
        output in_px_rd,
        output out_px, out_px_wr,
        output out_pivot, out_pivot_wr,
        output out_buff_size, out_buff_size_wr,
        output out_median_pos, out_median_pos_wr,
        output out_second_median_value, out_second_median_value_wr
    );

    // FIFO side: supplies pixels and full flags, observes the actor's writes.
    modport slave (
        output in_px, in_px_empty,
        output out_px_full, out_pivot_full, out_buff_size_full,
        output out_median_pos_full, out_second_median_value_full,
        input  in_px_rd,
        input  out_px, out_px_wr,
        input  out_pivot, out_pivot_wr,
        input  out_buff_size, out_buff_size_wr,
        input  out_median_pos, out_median_pos_wr,
        input  out_second_median_value, out_second_median_value_wr
    );
endinterface

// File: rtl/median_first_actor.sv
// Head actor of the median-filter chain. Collects BUFF_SIZE pixels into a
// local buffer while accumulating their sum, emits one header token set whose
// pivot is the window mean, then replays the window to the first middle actor.
// FILL, HEADER and DRAIN are mutually exclusive, so reads and writes never
// overlap.
module median_first_actor #(
    parameter logic [10:0] MEDIAN_POS    = 11'd512,
    parameter logic [10:0] BUFF_SIZE     = 11'd1024,
    parameter int          BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
    parameter logic [7:0]  DEFAULT_PIVOT = 8'd127
) (
    input  logic                 clock,
    input  logic                 reset,
    median_first_actor_if.master bus
);
    localparam int                LOG2     = $clog2(BUFF_SIZE);
    localparam int                SUM_W    = 8 + LOG2;
    localparam logic [LOG2-1:0]   CNT_ONE  = LOG2'(1);
    localparam logic [LOG2-1:0]   CNT_LAST = LOG2'(BUFF_SIZE - 11'd1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t            state_r;
    logic [LOG2-1:0]   cnt_r;
    logic [SUM_W-1:0]  sum_r;
    logic [7:0]        pivot_r;
    logic [7:0]        mem_r [BUFF_SIZE];

    logic              fill_rd_s;
    logic              token_wr_s;
    logic              drain_wr_s;
    logic [7:0]        px_s;
    logic [SUM_W-1:0]  sum_next_s;

    // Decode the per-state handshakes; reset gates the read so nothing is popped while held.
    always_comb begin
        fill_rd_s  = 1'b0;
        token_wr_s = 1'b0;
        drain_wr_s = 1'b0;
        px_s       = 8'd0;
        sum_next_s = sum_r + SUM_W'(bus.in_px);
        case (state_r)
            ST_FILL: begin
                fill_rd_s = reset & ~bus.in_px_empty;
            end
            ST_HEADER: begin
                // The token set is all-or-nothing so downstream never sees a partial header.
                token_wr_s = ~(bus.out_pivot_full | bus.out_buff_size_full |
                               bus.out_median_pos_full | bus.out_second_median_value_full);
            end
            ST_DRAIN: begin
                drain_wr_s = ~bus.out_px_full;
                px_s       = mem_r[cnt_r];
            end
            default: begin
                fill_rd_s  = 1'b0;
                token_wr_s = 1'b0;
                drain_wr_s = 1'b0;
                px_s       = 8'd0;
            end
        endcase
    end

    // Window buffer: written in arrival order, read back by the same counter in DRAIN.
    always_ff @(posedge clock) begin
        if (fill_rd_s) begin
            mem_r[cnt_r] <= bus.in_px;
        end
    end

    // Phase sequencer with position counter, running sum and pivot register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_FILL;
            cnt_r   <= '0;
            sum_r   <= '0;
            pivot_r <= DEFAULT_PIVOT;
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (fill_rd_s) begin
                        sum_r <= sum_next_s;
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r == CNT_LAST) begin
                            // Power-of-two window: the mean is a plain right shift.
                            pivot_r <= sum_next_s[SUM_W-1:LOG2];
                            state_r <= ST_HEADER;
                        end
                    end
                end
                ST_HEADER: begin
                    if (token_wr_s) begin
                        sum_r   <= '0;
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_wr_s) begin
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r == CNT_LAST) begin
                            state_r <= ST_FILL;
                        end
                    end
                end
                default: begin
                    state_r <= ST_FILL;
                    cnt_r   <= '0;
                    sum_r   <= '0;
                end
            endcase
        end
    end

    assign bus.in_px_rd                   = fill_rd_s;
    assign bus.out_px                     = px_s;
    assign bus.out_px_wr                  = drain_wr_s;
    assign bus.out_pivot                  = pivot_r;
    assign bus.out_pivot_wr               = token_wr_s;
    assign bus.out_buff_size              = BUFF_SIZE_BIT'(BUFF_SIZE);
    assign bus.out_buff_size_wr           = token_wr_s;
    assign bus.out_median_pos             = BUFF_SIZE_BIT'(MEDIAN_POS);
    assign bus.out_median_pos_wr          = token_wr_s;
    assign bus.out_second_median_value    = 8'd0;
    assign bus.out_second_median_value_wr = token_wr_s;

endmodule

// File: doc/median_first_actor.md
Name: median_first_actor

Overview:
Head actor of the median-filter chain and the producer for the median actor input FIFOs.
- Consumes a raw pixel stream and groups it into windows of BUFF_SIZE pixels, stored in an internal buffer.
- Computes each window's mean as the initial pivot.
- Writes one header token set (pivot, buff_size, median_pos, second_median_value), then replays the window's pixels, all through FIFO write/full handshakes into the first middle actor.

Parameters:
MEDIAN_POS, 11'd512, rank of the median within a window, forwarded as a token.
BUFF_SIZE, 11'd1024, pixels per window; must be a power of two and at least 2.
BUFF_SIZE_BIT, $clog2(BUFF_SIZE)+1, width of the size and position tokens.
DEFAULT_PIVOT, 8'd127, value of out_pivot after reset, before the first window completes.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_px  in  8  input pixel data.
in_px_rd  out  1  pops in_px.
in_px_empty  in  1  input FIFO empty.
out_px  out  8  pixel to the first middle actor.
out_px_wr  out  1  pushes out_px.
out_px_full  in  1  pixel FIFO full.
out_pivot  out  8  initial pivot token.
out_pivot_wr  out  1  pushes out_pivot.
out_pivot_full  in  1  pivot FIFO full.
out_buff_size  out  BUFF_SIZE_BIT  window size token.
out_buff_size_wr  out  1  pushes out_buff_size.
out_buff_size_full  in  1  size FIFO full.
out_median_pos  out  BUFF_SIZE_BIT  median rank token.
out_median_pos_wr  out  1  pushes out_median_pos.
out_median_pos_full  in  1  rank FIFO full.
out_second_median_value  out  8  second-median token.
out_second_median_value_wr  out  1  pushes out_second_median_value.
out_second_median_value_full  in  1  second-median FIFO full.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=FILL; cnt=0; sum=0; pivot register=DEFAULT_PIVOT.
  - All *_rd and *_wr outputs are 0; out_px=0.
- Buffer and accumulator:
  - Buffer: BUFF_SIZE x 8 register array with combinational read.
  - sum: 8+log2(BUFF_SIZE) bits, unsigned, never overflows.
  - cnt: log2(BUFF_SIZE) bits.
- FILL state:
  - in_px_rd = ~in_px_empty (combinational).
  - On each rd cycle: mem[cnt] <= in_px; sum <= sum+in_px; cnt <= cnt+1.
  - On the rd with cnt==BUFF_SIZE-1: pivot <= (sum+in_px)>>log2(BUFF_SIZE) (truncating); cnt wraps to 0; state <= HEADER.
  - Output FIFOs are ignored in this state.
- HEADER state:
  - All four token _wr assert together only when none of the four token FIFOs is full; otherwise all four stay 0 and the state holds.
  - Data on the write cycle:
    - out_pivot = pivot register.
    - out_buff_size = BUFF_SIZE.
    - out_median_pos = MEDIAN_POS.
    - out_second_median_value = 8'd0.
  - After the write cycle: sum <= 0; state <= DRAIN.
  - Token data outputs hold these values at all times outside reset.
- DRAIN state:
  - out_px = mem[cnt]; out_px_wr = ~out_px_full.
  - On each wr: cnt <= cnt+1.
  - On the wr with cnt==BUFF_SIZE-1: cnt <= 0; state <= FILL.
  - in_px_rd = 0.
  - Outside DRAIN, out_px = 0.
- Latency and throughput:
  - First pixel appears 2 cycles after the last input pixel is read: 1 cycle HEADER, then DRAIN, assuming FIFOs are not full.
  - Sustained rate is one pixel per cycle in both FILL and DRAIN.
- Full/empty handling:
  - out_px_full stalls DRAIN with cnt and data held; no data is lost or duplicated.
  - in_px_empty stalls FILL.
- No *_rd and *_wr asserts on the same cycle in different phases (FILL and DRAIN are exclusive).
- Reset mid-window discards the partial window; no partial header is ever emitted.

Test Plan:
(Use BUFF_SIZE=16, MEDIAN_POS=8, BUFF_SIZE_BIT=5 unless stated.)
1. Reset values: hold reset low 3 cycles -> all rd/wr=0, out_px=0, out_pivot=127; after release, in_px_rd follows ~in_px_empty.
2. Basic window: feed pixels 0..15 with FIFOs never full -> exactly one write each of pivot=7 (sum 120 >> 4), buff_size=16, median_pos=8, second_median_value=0; then 16 out_px writes of 0..15 in order.
3. Token backpressure: hold out_median_pos_full=1 for 5 cycles during HEADER -> no token _wr asserts; after release, all four write in the same single cycle.
4. Pixel backpressure: toggle out_px_full every other cycle in DRAIN -> output sequence is 0..15 with no gaps or repeats; 16 writes total.
5. Two windows: all 255s, then all 0s -> pivots 255 then 0; in_px_rd=0 throughout the first DRAIN; the second header is written only after the 16th pixel of window 1.
6. Reset mid-operation: assert reset after 9 pixels of a window -> no token writes occur; then a fresh 16-pixel window of value 10 -> pivot=10.
